periodic_irq_gen: RTL and testbench

Multi-channel periodic interrupt generator. It replaces the single hard-wired interrupt divider in board tops with N independent programmable channels. Each channel has a runtime-writable period, a periodic or one-shot mode, a latched request with level clear, and a missed-event counter. The irq outputs drive MCU ei_req (OR-reduced or per channel); the clr inputs come from an MCU port bit.

---
 rtl/periodic_irq_gen.sv | 108 ++++++++++
 tb/tb_periodic_irq_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/periodic_irq_gen.sv
// Multi-channel periodic interrupt generator: per-channel programmable
// period, periodic/one-shot mode, latched request and missed-event count.
module periodic_irq_gen #(
  parameter int N_CH           = 2,
  parameter int CNT_W          = 16,
  parameter int MISS_W         = 4,
  parameter int DEFAULT_PERIOD = 6249,
  parameter int DEFAULT_MODE   = 1,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [CNT_W-1:0]         cfg_period,
  input  logic [1:0]               cfg_mode,
  input  logic [N_CH-1:0]          clr,
  output logic [N_CH-1:0]          tick,
  output logic [N_CH-1:0]          irq,
  output logic                     irq_any,
  output logic [N_CH*MISS_W-1:0]   miss_cnt
);

  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);
  localparam logic [1:0]       DEF_M = 2'(DEFAULT_MODE);

  localparam logic [1:0] M_OFF  = 2'd0;
  localparam logic [1:0] M_ONE  = 2'd2;
  localparam logic [1:0] M_RSVD = 2'd3;

  logic [N_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_CH-1:0][CNT_W-1:0]  period_q, period_d;
  logic [N_CH-1:0][1:0]        mode_q, mode_d;
  logic [N_CH-1:0][MISS_W-1:0] miss_q, miss_d;
  logic [N_CH-1:0]             tick_q, tick_d;
  logic [N_CH-1:0]             irq_q, irq_d;
  logic                        any_q, any_d;
  logic [N_CH-1:0]             hit, at_term, term;

  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    mode_d   = mode_q;
    miss_d   = miss_q;
    tick_d   = '0;
    irq_d    = irq_q;
    hit      = '0;
    at_term  = '0;
    term     = '0;
    for (int k = 0; k < N_CH; k++) begin
      hit[k]     = cfg_we && (cfg_ch == CH_W'(k));
      at_term[k] = (cnt_q[k] == period_q[k]);
      term[k]    = (mode_q[k] != M_OFF) && at_term[k] && !hit[k];
      tick_d[k]  = term[k];

      if (hit[k]) begin
        period_d[k] = cfg_period;
        mode_d[k]   = (cfg_mode == M_RSVD) ? M_OFF : cfg_mode;
        cnt_d[k]    = '0;
      end else if (mode_q[k] == M_OFF) begin
        cnt_d[k] = '0;
      end else if (at_term[k]) begin
        cnt_d[k] = '0;
        if (mode_q[k] == M_ONE)
          mode_d[k] = M_OFF;
      end else begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end

      // clear wins over a coincident terminal event
      if (clr[k]) begin
        irq_d[k]  = 1'b0;
        miss_d[k] = '0;
      end else begin
        irq_d[k] = term[k] | irq_q[k];
        if (term[k] && irq_q[k] && !(&miss_q[k]))
          miss_d[k] = miss_q[k] + MISS_W'(1);
      end
    end
    any_d = |irq_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      period_q <= {N_CH{DEF_P}};
      mode_q   <= {N_CH{DEF_M}};
      miss_q   <= '0;
      tick_q   <= '0;
      irq_q    <= '0;
      any_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      miss_q   <= miss_d;
      tick_q   <= tick_d;
      irq_q    <= irq_d;
      any_q    <= any_d;
    end
  end

  assign tick     = tick_q;
  assign irq      = irq_q;
  assign irq_any  = any_q;
  assign miss_cnt = miss_q;

endmodule

// File: tb/tb_periodic_irq_gen.sv
// Scoreboard bench for periodic_irq_gen: a cycle model predicts every
// output per edge; directed checks cover the listed corner cases.
module tb_periodic_irq_gen;

  localparam int N  = 3;
  localparam int CW = 16;
  localparam int MW = 4;
  localparam int DP = 6249;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            cfg_we = 1'b0;
  logic [1:0]      cfg_ch = '0;
  logic [CW-1:0]   cfg_period = '0;
  logic [1:0]      cfg_mode = '0;
  logic [N-1:0]    clr = '0;
  logic [N-1:0]    tick, irq;
  logic            irq_any;
  logic [N*MW-1:0] miss_cnt;

  periodic_irq_gen #(
    .N_CH(N), .CNT_W(CW), .MISS_W(MW),
    .DEFAULT_PERIOD(DP), .DEFAULT_MODE(1)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_mode(cfg_mode),
    .clr(clr), .tick(tick), .irq(irq),
    .irq_any(irq_any), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]    tick;
    logic [N-1:0]    irq;
    logic            any;
    logic [N*MW-1:0] miss;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_t[N];
  int first_t[N];

  logic [CW-1:0] m_cnt[N];
  logic [CW-1:0] m_per[N];
  logic [1:0]    m_mode[N];
  logic          m_irq[N];
  logic [MW-1:0] m_miss[N];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got=%0h want=%0h (cyc %0d)",
               tag, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_cnt[k]  = '0;
      m_per[k]  = CW'(DP);
      m_mode[k] = 2'd1;
      m_irq[k]  = 1'b0;
      m_miss[k] = '0;
    end
  endtask

  task automatic clr_stats();
    for (int k = 0; k < N; k++) begin
      n_t[k] = 0;
      first_t[k] = 0;
    end
    cyc = 0;
  endtask

  // Predict the next edge from model state and current inputs, then
  // step one clock and compare the DUT against the popped prediction.
  task automatic cycle();
    exp_t e;
    exp_t g;
    logic hit, t, old;
    e = '0;
    if (reset) begin
      model_reset();
    end else begin
      for (int k = 0; k < N; k++) begin
        hit = cfg_we && (int'(cfg_ch) == k);
        t = (m_mode[k] != 2'd0) && (m_cnt[k] == m_per[k]) && !hit;
        e.tick[k] = t;
        old = m_irq[k];
        if (clr[k]) begin
          m_irq[k]  = 1'b0;
          m_miss[k] = '0;
        end else begin
          if (t && old && m_miss[k] != 4'hF)
            m_miss[k] = m_miss[k] + 4'd1;
          if (t)
            m_irq[k] = 1'b1;
        end
        if (hit) begin
          m_per[k]  = cfg_period;
          m_mode[k] = (cfg_mode == 2'd3) ? 2'd0 : cfg_mode;
          m_cnt[k]  = '0;
        end else if (m_mode[k] == 2'd0) begin
          m_cnt[k] = '0;
        end else if (m_cnt[k] == m_per[k]) begin
          m_cnt[k] = '0;
          if (m_mode[k] == 2'd2)
            m_mode[k] = 2'd0;
        end else begin
          m_cnt[k] = m_cnt[k] + 16'd1;
        end
        e.irq[k] = m_irq[k];
        e.miss[k*MW +: MW] = m_miss[k];
      end
      e.any = |e.irq;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    g = exp_q.pop_front();
    check("tick", 64'(tick), 64'(g.tick));
    check("irq", 64'(irq), 64'(g.irq));
    check("irq_any", 64'(irq_any), 64'(g.any));
    check("miss_cnt", 64'(miss_cnt), 64'(g.miss));
    for (int k = 0; k < N; k++) begin
      if (tick[k]) begin
        n_t[k]++;
        if (first_t[k] == 0)
          first_t[k] = cyc;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++)
      cycle();
  endtask

  task automatic write_cfg(input logic [1:0] ch,
                           input logic [CW-1:0] p,
                           input logic [1:0] m);
    cfg_we = 1'b1;
    cfg_ch = ch;
    cfg_period = p;
    cfg_mode = m;
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tick"}, 64'(tick), 64'h0);
    check({tag, "_irq"}, 64'(irq), 64'h0);
    check({tag, "_any"}, 64'(irq_any), 64'h0);
    check({tag, "_miss"}, 64'(miss_cnt), 64'h0);
  endtask

  initial begin
    bit found;
    model_reset();
    clr_stats();
    #2 reset = 1'b1;
    #1 check_zero("rst");
    @(posedge clk);
    #1 reset = 1'b0;

    // defaults: every channel ticks after edge 6250, then every 6250
    run(2 * (DP + 1));
    check("def_first0", 64'(first_t[0]), 64'(DP + 1));
    check("def_first1", 64'(first_t[1]), 64'(DP + 1));
    check("def_nt0", 64'(n_t[0]), 64'd2);
    check("def_irq0", 64'(irq[0]), 64'd1);
    check("def_miss0", 64'(miss_cnt[3:0]), 64'd1);

    clr = '1;
    cycle();
    clr = '0;

    // ch1 period 3: miss count saturates, then one-cycle clear
    write_cfg(2'd1, 16'd3, 2'd1);
    clr_stats();
    run(68);
    check("p3_first1", 64'(first_t[1]), 64'd4);
    check("p3_nt1", 64'(n_t[1]), 64'd17);
    check("p3_sat", 64'(miss_cnt[7:4]), 64'd15);
    clr = 3'b010;
    cycle();
    clr = '0;
    check("clr_irq1", 64'(irq[1]), 64'd0);
    check("clr_miss1", 64'(miss_cnt[7:4]), 64'd0);

    // one-shot on ch0
    write_cfg(2'd0, 16'd5, 2'd2);
    clr_stats();
    run(106);
    check("os_first0", 64'(first_t[0]), 64'd6);
    check("os_nt0", 64'(n_t[0]), 64'd1);

    // period 0 on ch2 with clear held high
    clr = 3'b100;
    write_cfg(2'd2, 16'd0, 2'd1);
    clr_stats();
    run(20);
    check("p0_nt2", 64'(n_t[2]), 64'd20);
    check("p0_irq2", 64'(irq[2]), 64'd0);
    check("p0_miss2", 64'(miss_cnt[11:8]), 64'd0);
    clr = '0;

    // write landing exactly on ch0's terminal count
    write_cfg(2'd0, 16'd4, 2'd1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_cnt[0] == m_per[0]) found = 1'b1;
      else cycle();
    end
    check("coll_reach", 64'(found), 64'd1);
    write_cfg(2'd0, 16'd7, 2'd1);
    check("coll_tick0", 64'(tick[0]), 64'd0);
    clr_stats();
    run(8);
    check("coll_first0", 64'(first_t[0]), 64'd8);

    // clear coincident with a ch1 terminal event
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_cnt[1] == m_per[1]) found = 1'b1;
      else cycle();
    end
    check("clrterm_reach", 64'(found), 64'd1);
    clr = 3'b010;
    cycle();
    clr = '0;
    check("clrterm_tick1", 64'(tick[1]), 64'd1);
    check("clrterm_irq1", 64'(irq[1]), 64'd0);

    // build irq=1, miss=7 on ch1, then async reset mid-cycle
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_miss[1] == 4'd7) found = 1'b1;
      else cycle();
    end
    check("ar_reach", 64'(found), 64'd1);
    check("ar_irq1", 64'(irq[1]), 64'd1);
    check("ar_miss1", 64'(miss_cnt[7:4]), 64'd7);
    #2 reset = 1'b1;
    #1 check_zero("arst");
    model_reset();
    cycle();
    reset = 1'b0;

    // out-of-range channel write must change nothing
    clr_stats();
    write_cfg(2'd3, 16'd1, 2'd1);
    run(DP);
    check("ar_first0", 64'(first_t[0]), 64'(DP + 1));
    check("ar_first1", 64'(first_t[1]), 64'(DP + 1));
    check("ar_first2", 64'(first_t[2]), 64'(DP + 1));

    check("q_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
